// File: rtl/tsen_poll_ctrl.sv
// tsen_poll_ctrl: autonomous crossbar host that polls the temperature
// sensor data register, keeps the last reading and flags over-temperature.
//
// Ports:
//   clk_i, rst_i    clock, synchronous active-high reset
//   en_i            polling enable (level)
//   clr_i           one-cycle pulse, clears err_o / timeout_o
//   period_i        idle cycles between a response and the next request
//   thresh_hi_i     unsigned alarm threshold
//   tl_o / tl_i     TL-UL host side (A channel + d_ready / D channel + a_ready)
//   temp_o          last good 16-bit sample
//   temp_valid_o    one-cycle pulse when temp_o updates
//   alarm_o         temp_o >= thresh_hi_i, updated per good sample
//   err_o           sticky, a response carried d_error
//   timeout_o       sticky, a response took TIMEOUT cycles or more
//   busy_o          poll engine not idle

package tlul_pkg;

   localparam logic [2:0] GET = 3'h4;

   typedef struct packed {
      logic        a_valid;
      logic [2:0]  a_opcode;
      logic [2:0]  a_param;
      logic [1:0]  a_size;
      logic [7:0]  a_source;
      logic [31:0] a_address;
      logic [3:0]  a_mask;
      logic [31:0] a_data;
      logic        d_ready;
   } tl_h2d_t;

   typedef struct packed {
      logic        d_valid;
      logic [2:0]  d_opcode;
      logic [2:0]  d_param;
      logic [1:0]  d_size;
      logic [7:0]  d_source;
      logic        d_sink;
      logic [31:0] d_data;
      logic        d_error;
      logic        a_ready;
   } tl_d2h_t;

   localparam tl_h2d_t TL_H2D_DEFAULT = '0;

endpackage

package xbar_pkg;

   localparam logic [31:0] ADDR_SPACE_TSEN1 = 32'h4011_0000;

endpackage

module tsen_poll_ctrl
   import tlul_pkg::*;
#(
   parameter logic [31:0] TSEN_ADDR = xbar_pkg::ADDR_SPACE_TSEN1,
   parameter int unsigned PERIOD_W  = 16,
   parameter int unsigned TIMEOUT   = 255
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                en_i,
   input  logic                clr_i,
   input  logic [PERIOD_W-1:0] period_i,
   input  logic [15:0]         thresh_hi_i,
   output tl_h2d_t             tl_o,
   input  tl_d2h_t             tl_i,
   output logic [15:0]         temp_o,
   output logic                temp_valid_o,
   output logic                alarm_o,
   output logic                err_o,
   output logic                timeout_o,
   output logic                busy_o
);

   localparam int unsigned TO_W = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      RESP,
      WAIT
   } state_e;

   state_e state_q;
   state_e state_d;

   logic [TO_W-1:0]     to_cnt_q;
   logic [PERIOD_W-1:0] per_cnt_q;

   logic a_hs;
   logic d_hs;
   logic d_good;
   logic d_bad;
   logic to_hit;
   logic [15:0] d_temp;

   // State register
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state and TL-UL outputs. A-channel fields are constants while
   // in REQ, so they cannot move before the handshake.
   always_comb begin
      state_d = state_q;
      tl_o    = TL_H2D_DEFAULT;
      unique case (state_q)
         IDLE: begin
            if (en_i) begin
               state_d = REQ;
            end
         end
         REQ: begin
            tl_o.a_valid   = 1'b1;
            tl_o.a_opcode  = GET;
            tl_o.a_size    = 2'd2;
            tl_o.a_mask    = 4'hf;
            tl_o.a_address = TSEN_ADDR;
            if (tl_i.a_ready) begin
               state_d = RESP;
            end
         end
         RESP: begin
            tl_o.d_ready = 1'b1;
            if (tl_i.d_valid) begin
               state_d = en_i ? WAIT : IDLE;
            end
         end
         WAIT: begin
            if (!en_i) begin
               state_d = IDLE;
            end else if (per_cnt_q == '0) begin
               state_d = REQ;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign a_hs   = tl_o.a_valid & tl_i.a_ready;
   assign d_hs   = tl_o.d_ready & tl_i.d_valid;
   assign d_good = d_hs & ~tl_i.d_error;
   assign d_bad  = d_hs & tl_i.d_error;
   assign d_temp = tl_i.d_data[15:0];

   // Fires in the RESP cycle that completes TIMEOUT cycles of waiting;
   // the counter saturates so this can only happen once per transaction.
   assign to_hit = (state_q == RESP) &&
                   (to_cnt_q == TO_W'(TIMEOUT - 1));

   // Response timeout counter, restarted on every A handshake
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         to_cnt_q <= '0;
      end else if (a_hs) begin
         to_cnt_q <= '0;
      end else if (state_q == RESP &&
                   to_cnt_q != TO_W'(TIMEOUT)) begin
         to_cnt_q <= to_cnt_q + TO_W'(1);
      end
   end

   // Inter-sample period: period_i is captured once, on the response
   // that enters WAIT, so later changes only affect the next period.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         per_cnt_q <= '0;
      end else if (d_hs) begin
         per_cnt_q <= period_i;
      end else if (state_q == WAIT && per_cnt_q != '0) begin
         per_cnt_q <= per_cnt_q - PERIOD_W'(1);
      end
   end

   // Sample capture and alarm compare
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         temp_o       <= '0;
         temp_valid_o <= 1'b0;
         alarm_o      <= 1'b0;
      end else begin
         temp_valid_o <= d_good;
         if (d_good) begin
            temp_o  <= d_temp;
            alarm_o <= (d_temp >= thresh_hi_i);
         end
      end
   end

   // Sticky flags; a set event beats a coincident clear
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         err_o     <= 1'b0;
         timeout_o <= 1'b0;
      end else begin
         if (d_bad) begin
            err_o <= 1'b1;
         end else if (clr_i) begin
            err_o <= 1'b0;
         end
         if (to_hit) begin
            timeout_o <= 1'b1;
         end else if (clr_i) begin
            timeout_o <= 1'b0;
         end
      end
   end

   assign busy_o = (state_q != IDLE);

   // Response metadata and the upper data half carry nothing we use
   logic unused_tl;
   assign unused_tl = ^{tl_i.d_opcode, tl_i.d_param, tl_i.d_size,
                        tl_i.d_source, tl_i.d_sink,
                        tl_i.d_data[31:16]};

endmodule

// File: tb/tb_tsen_poll_ctrl.sv
// tb_tsen_poll_ctrl: directed bench for tsen_poll_ctrl.
// Table of poll vectors plus hand-written multi-cycle sequences.

module tb_tsen_poll_ctrl;
   import tlul_pkg::*;

   localparam logic [31:0] ADDR = 32'h4011_0000;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        en;
   logic        clr;
   logic [15:0] period;
   logic [15:0] thresh;
   tl_h2d_t     tl_o;
   tl_d2h_t     tl_i;
   logic [15:0] temp;
   logic        temp_valid;
   logic        alarm;
   logic        err;
   logic        timeout;
   logic        busy;

   int n_checks = 0;
   int n_fail   = 0;

   tsen_poll_ctrl dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .en_i         (en),
      .clr_i        (clr),
      .period_i     (period),
      .thresh_hi_i  (thresh),
      .tl_o         (tl_o),
      .tl_i         (tl_i),
      .temp_o       (temp),
      .temp_valid_o (temp_valid),
      .alarm_o      (alarm),
      .err_o        (err),
      .timeout_o    (timeout),
      .busy_o       (busy)
   );

   typedef struct {
      logic [15:0] thresh;
      logic [31:0] data;
      logic        derr;
      logic [15:0] e_temp;
      logic        e_alarm;
      logic        e_err;
      logic        e_valid;
   } vec_t;

   vec_t vecs[8];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name,
                      input logic [31:0] act,
                      input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic tl_h2d_t exp_req();
      tl_h2d_t r;
      r           = '0;
      r.a_valid   = 1'b1;
      r.a_opcode  = 3'h4;
      r.a_size    = 2'd2;
      r.a_mask    = 4'hf;
      r.a_address = ADDR;
      return r;
   endfunction

   task automatic chk_req(input string name);
      n_checks++;
      if (tl_o !== exp_req()) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h",
                  name, tl_o, exp_req());
      end
   endtask

   task automatic wait_req();
      for (int i = 0; i < 64 && !tl_o.a_valid; i++) tick();
      chk("wait_req", tl_o.a_valid, 1);
   endtask

   task automatic hs();
      tl_i.a_ready = 1'b1;
      tick();
      tl_i.a_ready = 1'b0;
   endtask

   task automatic rsp(input logic [31:0] data, input logic e);
      tl_i.d_valid = 1'b1;
      tl_i.d_data  = data;
      tl_i.d_error = e;
      tick();
      tl_i.d_valid = 1'b0;
      tl_i.d_error = 1'b0;
      tl_i.d_data  = '0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int cnt;
      rst    = 1'b1;
      en     = 1'b0;
      clr    = 1'b0;
      period = '0;
      thresh = 16'h0100;
      tl_i   = '0;
      tl_i.d_opcode = 3'h1;

      vecs[0] = '{16'h0100, 32'h0000_00ff, 0, 16'h00ff, 0, 0, 1};
      vecs[1] = '{16'h0100, 32'h0000_0100, 0, 16'h0100, 1, 0, 1};
      vecs[2] = '{16'h0100, 32'h0000_0000, 1, 16'h0100, 1, 1, 0};
      vecs[3] = '{16'h8000, 32'habcd_7fff, 0, 16'h7fff, 0, 1, 1};
      vecs[4] = '{16'h8000, 32'h0000_ffff, 0, 16'hffff, 1, 1, 1};
      vecs[5] = '{16'hffff, 32'h1234_ffff, 0, 16'hffff, 1, 1, 1};
      vecs[6] = '{16'h0000, 32'h0000_0000, 0, 16'h0000, 1, 1, 1};
      vecs[7] = '{16'h0001, 32'hffff_0000, 0, 16'h0000, 0, 1, 1};

      tick();
      tick();
      rst = 1'b0;
      tick();
      chk("rst_avalid", tl_o.a_valid, 0);
      chk("rst_dready", tl_o.d_ready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_temp", temp, 0);
      chk("rst_tvalid", temp_valid, 0);
      chk("rst_alarm", alarm, 0);
      chk("rst_err", err, 0);
      chk("rst_timeout", timeout, 0);

      // basic poll
      period = 16'd4;
      en     = 1'b1;
      chk("idle_avalid", tl_o.a_valid, 0);
      tick();
      chk_req("first_req");
      chk("first_busy", busy, 1);
      hs();
      chk("resp_dready", tl_o.d_ready, 1);
      chk("resp_avalid", tl_o.a_valid, 0);
      rsp(32'h0000_0123, 1'b0);
      chk("basic_temp", temp, 16'h0123);
      chk("basic_tvalid", temp_valid, 1);
      chk("basic_alarm", alarm, 1);
      for (int i = 1; i <= 5; i++) begin
         tick();
         chk("period4_avalid", tl_o.a_valid, (i == 5));
         chk("period4_tvalid", temp_valid, 0);
      end

      // backpressure
      for (int i = 0; i < 10; i++) begin
         chk_req("bp_hold");
         tick();
      end
      chk_req("bp_hold_last");
      hs();
      chk("bp_after_hs", tl_o.a_valid, 0);
      period = 16'd50;
      rsp(32'h0000_0055, 1'b0);
      chk("bp_temp", temp, 16'h0055);
      chk("bp_alarm", alarm, 0);
      period = 16'd2;
      cnt = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (tl_o.a_valid) cnt++;
      end
      chk("bp_no_dup", cnt, 0);
      en = 1'b0;
      tick();
      chk("wait_disable_busy", busy, 0);

      // table of polls, back-to-back
      period = 16'd0;
      en     = 1'b1;
      for (int v = 0; v < 8; v++) begin
         thresh = vecs[v].thresh;
         wait_req();
         hs();
         rsp(vecs[v].data, vecs[v].derr);
         chk("vec_temp", temp, vecs[v].e_temp);
         chk("vec_alarm", alarm, vecs[v].e_alarm);
         chk("vec_err", err, vecs[v].e_err);
         chk("vec_tvalid", temp_valid, vecs[v].e_valid);
      end
      tick();
      chk("b2b_req", tl_o.a_valid, 1);

      // timeout
      wait_req();
      hs();
      for (int k = 1; k <= 300; k++) begin
         tick();
         if (k == 254) chk("to_before", timeout, 0);
         if (k == 255) chk("to_at_255", timeout, 1);
      end
      chk("to_still_resp", tl_o.d_ready, 1);
      chk("to_busy", busy, 1);
      rsp(32'h0000_0042, 1'b0);
      chk("to_late_temp", temp, 16'h0042);
      chk("to_late_tvalid", temp_valid, 1);
      chk("to_sticky", timeout, 1);
      clr = 1'b1;
      tick();
      clr = 1'b0;
      chk("clr_timeout", timeout, 0);
      chk("clr_err", err, 0);

      // clear coinciding with an error response
      wait_req();
      hs();
      clr = 1'b1;
      rsp(32'h0000_0000, 1'b1);
      clr = 1'b0;
      chk("clr_vs_set_err", err, 1);
      chk("clr_vs_set_temp", temp, 16'h0042);
      chk("clr_vs_set_tv", temp_valid, 0);
      chk("clr_vs_set_to", timeout, 0);

      // disable mid-flight
      wait_req();
      en = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk_req("dis_hold");
      end
      hs();
      rsp(32'h0000_0077, 1'b0);
      chk("dis_temp", temp, 16'h0077);
      chk("dis_busy", busy, 0);
      tl_i.d_valid = 1'b1;
      tl_i.d_data  = 32'h0000_dead;
      tick();
      tl_i.d_valid = 1'b0;
      tl_i.d_data  = '0;
      chk("stray_temp", temp, 16'h0077);
      chk("stray_tvalid", temp_valid, 0);
      cnt = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (tl_o.a_valid) cnt++;
      end
      chk("dis_no_req", cnt, 0);

      // reset mid-transaction
      en = 1'b1;
      wait_req();
      hs();
      chk("mid_dready", tl_o.d_ready, 1);
      chk("mid_alarm_pre", alarm, 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      en  = 1'b0;
      chk("mrst_avalid", tl_o.a_valid, 0);
      chk("mrst_dready", tl_o.d_ready, 0);
      chk("mrst_temp", temp, 0);
      chk("mrst_tvalid", temp_valid, 0);
      chk("mrst_alarm", alarm, 0);
      chk("mrst_err", err, 0);
      chk("mrst_timeout", timeout, 0);
      chk("mrst_busy", busy, 0);
      tick();
      chk("mrst_idle", tl_o.a_valid, 0);
      en = 1'b1;
      tick();
      chk_req("fresh_req");

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
